// File: rtl/matrix_pair_loader_if.sv
// Element stream into matrix_pair_loader: a beat happens on a rising edge where
// i_valid and o_accept are both high; i_data is only meaningful while i_valid is high.
interface matrix_pair_loader_if #(
   parameter int DATA_WIDTH = 16
);
   logic [DATA_WIDTH-1:0] i_data;
   logic                  i_valid;
   logic                  o_accept;

   modport master (output i_data, output i_valid, input o_accept);
   modport slave  (input i_data, input i_valid, output o_accept);
endinterface

// File: rtl/matrix_pair_loader.sv
// Packs a serial element stream into operand matrices A then B and holds them under calc_cmd
// until the summing stage reports done. Optional CALC watchdog: MATRIX_LOADER_TIMEOUT_EN.
module matrix_pair_loader #(
   parameter int MATRIX_SIZE_M  = 3,
   parameter int MATRIX_SIZE_N  = 2,
   parameter int DATA_WIDTH     = 16,
   parameter int TIMEOUT_CYCLES = 1024,
   localparam int ELEMS         = MATRIX_SIZE_M * MATRIX_SIZE_N,
   localparam int SIZE_BLOCK    = ELEMS * DATA_WIDTH
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   matrix_pair_loader_if.slave   stream,
   output logic [SIZE_BLOCK-1:0] o_matrix_a,
   output logic [SIZE_BLOCK-1:0] o_matrix_b,
   output logic                  o_calc_cmd,
   input  logic                  i_calc_done,
   output logic                  o_timeout,
   output logic [1:0]            o_dbg_state
);
   localparam int IDX_W = (ELEMS > 1) ? $clog2(ELEMS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ELEMS - 1);

   typedef enum logic [1:0] {
      LOAD_A = 2'd0,
      LOAD_B = 2'd1,
      CALC   = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [SIZE_BLOCK-1:0] matrix_a_q, matrix_a_d;
   logic [SIZE_BLOCK-1:0] matrix_b_q, matrix_b_d;
   logic                  accept_q, accept_d;
   logic                  calc_cmd_q, calc_cmd_d;
   logic                  calc_first_q, calc_first_d;
   logic                  timeout_q, timeout_d;
   logic                  beat;
   logic                  last_beat;
   logic                  done_ok;
   logic                  wd_expire;

   assign beat      = stream.i_valid & accept_q;
   assign last_beat = beat & (idx_q == LAST_IDX);
   // The first CALC cycle may still see the done level left over from the previous op.
   assign done_ok   = (state_q == CALC) & ~calc_first_q & i_calc_done;

`ifdef MATRIX_LOADER_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0] wd_q, wd_d;

   assign wd_expire = (state_q == CALC) & (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      wd_d = '0;
      if (state_q == CALC) wd_d = wd_q + 1'b1;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) wd_q <= '0;
      else          wd_q <= wd_d;
   end
`else
   assign wd_expire = 1'b0;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state_q <= LOAD_A;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         LOAD_A:  if (last_beat) state_d = LOAD_B;
         LOAD_B:  if (last_beat) state_d = CALC;
         CALC:    if (done_ok || wd_expire) state_d = LOAD_A;
         default: state_d = LOAD_A;
      endcase
   end

   always_comb begin
      idx_d      = idx_q;
      matrix_a_d = matrix_a_q;
      matrix_b_d = matrix_b_q;
      if (beat) begin
         idx_d = last_beat ? '0 : idx_q + 1'b1;
         if (state_q == LOAD_A)
            matrix_a_d[SIZE_BLOCK-1-int'(idx_q)*DATA_WIDTH -: DATA_WIDTH] = stream.i_data;
         if (state_q == LOAD_B)
            matrix_b_d[SIZE_BLOCK-1-int'(idx_q)*DATA_WIDTH -: DATA_WIDTH] = stream.i_data;
      end
      accept_d     = (state_d != CALC);
      calc_cmd_d   = (state_d == CALC);
      calc_first_d = (state_q != CALC) && (state_d == CALC);
      timeout_d    = wd_expire & ~done_ok;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         idx_q        <= '0;
         matrix_a_q   <= '0;
         matrix_b_q   <= '0;
         accept_q     <= 1'b0;
         calc_cmd_q   <= 1'b0;
         calc_first_q <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         idx_q        <= idx_d;
         matrix_a_q   <= matrix_a_d;
         matrix_b_q   <= matrix_b_d;
         accept_q     <= accept_d;
         calc_cmd_q   <= calc_cmd_d;
         calc_first_q <= calc_first_d;
         timeout_q    <= timeout_d;
      end
   end

   assign stream.o_accept = accept_q;
   assign o_matrix_a      = matrix_a_q;
   assign o_matrix_b      = matrix_b_q;
   assign o_calc_cmd      = calc_cmd_q;
   assign o_timeout       = timeout_q;
   assign o_dbg_state     = state_q;
endmodule
